// File: rtl/fwd_hazard_ctrl_if.sv
// Bus between the RV32 pipeline and the forwarding/hazard controller.
// master: pipeline side, drives ID/EX/bypass state and flush, receives selects and stalls.
// slave : controller side (fwd_hazard_ctrl).
// Signals:
//   id_*            instruction currently in ID (sources, destination, multi-cycle flag)
//   ex_*            instruction currently in EX (sources, load flag, destination)
//   src_we/src_wr   bypass sources after EX, bit/slice k-1 = source k (1 = MEM, nearest)
//   flush           IF/ID flush this cycle
//   forward_a/b     EX operand bypass selects, 0 = regfile, k = source k
//   stall_if/id     hold PC / IF-ID register
//   bubble_ex       insert NOP into ID/EX
//   mc_busy/mc_done multi-cycle op in flight / last busy cycle
//   stall_cnt       saturating count of stalled cycles
interface fwd_hazard_ctrl_if #(
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned NSTAGE  = 2,
    parameter int unsigned CNT_W   = 32
);
    localparam int unsigned SEL_W = $clog2(NSTAGE + 1);

    logic                      id_valid;
    logic [RADDR_W-1:0]        id_rs1;
    logic [RADDR_W-1:0]        id_rs2;
    logic                      id_rs1_used;
    logic                      id_rs2_used;
    logic [RADDR_W-1:0]        id_wr;
    logic                      id_we;
    logic                      id_is_mc;
    logic [RADDR_W-1:0]        ex_rs1;
    logic [RADDR_W-1:0]        ex_rs2;
    logic                      ex_rs2_is_imm;
    logic                      ex_is_load;
    logic                      ex_we;
    logic [RADDR_W-1:0]        ex_wr;
    logic [NSTAGE-1:0]         src_we;
    logic [NSTAGE*RADDR_W-1:0] src_wr;
    logic                      flush;
    logic [SEL_W-1:0]          forward_a;
    logic [SEL_W-1:0]          forward_b;
    logic                      stall_if;
    logic                      stall_id;
    logic                      bubble_ex;
    logic                      mc_busy;
    logic                      mc_done;
    logic [CNT_W-1:0]          stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_wr, id_we, id_is_mc,
        output ex_rs1, ex_rs2, ex_rs2_is_imm, ex_is_load, ex_we, ex_wr,
        output src_we, src_wr, flush,
        input  forward_a, forward_b, stall_if, stall_id, bubble_ex, mc_busy, mc_done, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_wr, id_we, id_is_mc,
        input  ex_rs1, ex_rs2, ex_rs2_is_imm, ex_is_load, ex_we, ex_wr,
        input  src_we, src_wr, flush,
        output forward_a, forward_b, stall_if, stall_id, bubble_ex, mc_busy, mc_done, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for the RV32 pipeline.
// Picks the EX operand bypass source (nearest writer wins), detects load-use hazards and
// tracks one in-flight multi-cycle (MUL/DIV) op, stalling ID on RAW/WAW/structural conflicts.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  fwd_hazard_ctrl_if.slave, see the interface for the individual signals
module fwd_hazard_ctrl #(
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned NSTAGE  = 2,
    parameter int unsigned MC_LAT  = 4,
    parameter int unsigned CNT_W   = 32
) (
    input logic              clk,
    input logic              rst,
    fwd_hazard_ctrl_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(NSTAGE + 1);
    localparam int unsigned MCC_W = $clog2(MC_LAT);
    localparam logic [MCC_W-1:0] MC_LOAD = MCC_W'(MC_LAT - 1);

    // True when the valid ID instruction actually reads register r (x0 never counts).
    function automatic logic hit_f(input logic [RADDR_W-1:0] r,
                                   input logic               valid,
                                   input logic [RADDR_W-1:0] rs1,
                                   input logic               rs1_used,
                                   input logic [RADDR_W-1:0] rs2,
                                   input logic               rs2_used);
        return valid && (r != '0) && ((rs1_used && rs1 == r) || (rs2_used && rs2 == r));
    endfunction

    logic               mc_busy_q, mc_busy_d;
    logic [MCC_W-1:0]   mc_cnt_q, mc_cnt_d;
    logic [RADDR_W-1:0] mc_wr_q, mc_wr_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic [SEL_W-1:0]   fwd_a, fwd_b;
    logic [RADDR_W-1:0] src_wr_k;
    logic               lu, mc_raw, mc_waw, mc_struct, stall, stall_out, issue;

    // Scan furthest to nearest so the nearest matching source is the one left standing.
    always_comb begin
        fwd_a    = '0;
        fwd_b    = '0;
        src_wr_k = '0;
        for (int k = int'(NSTAGE) - 1; k >= 0; k--) begin
            src_wr_k = bus.src_wr[k*RADDR_W +: RADDR_W];
            if (bus.src_we[k] && src_wr_k != '0 && src_wr_k == bus.ex_rs1) begin
                fwd_a = SEL_W'(k + 1);
            end
            if (bus.src_we[k] && src_wr_k != '0 && src_wr_k == bus.ex_rs2) begin
                fwd_b = SEL_W'(k + 1);
            end
        end
        if (bus.ex_rs2_is_imm || rst) fwd_b = '0;
        if (rst) fwd_a = '0;
    end

    always_comb begin
        lu = bus.ex_is_load && bus.ex_we &&
             hit_f(bus.ex_wr, bus.id_valid, bus.id_rs1, bus.id_rs1_used,
                   bus.id_rs2, bus.id_rs2_used);
        mc_raw = mc_busy_q &&
                 hit_f(mc_wr_q, bus.id_valid, bus.id_rs1, bus.id_rs1_used,
                       bus.id_rs2, bus.id_rs2_used);
        mc_waw = mc_busy_q && bus.id_valid && bus.id_we && bus.id_wr == mc_wr_q &&
                 bus.id_wr != '0;
        mc_struct = mc_busy_q && bus.id_valid && bus.id_is_mc;
        stall     = lu || mc_raw || mc_waw || mc_struct;
        // A flushed ID instruction is dead, so it neither stalls nor requests a bubble.
        stall_out = stall && !bus.flush && !rst;
        issue     = bus.id_valid && bus.id_is_mc && !stall && !bus.flush;
    end

    always_comb begin
        mc_busy_d   = mc_busy_q;
        mc_cnt_d    = mc_cnt_q;
        mc_wr_d     = mc_wr_q;
        stall_cnt_d = stall_cnt_q;
        if (issue) begin
            mc_busy_d = 1'b1;
            mc_cnt_d  = MC_LOAD;
            mc_wr_d   = bus.id_we ? bus.id_wr : '0;
        end else if (mc_busy_q) begin
            if (mc_cnt_q == '0) begin
                mc_busy_d = 1'b0;
            end else begin
                mc_cnt_d = mc_cnt_q - 1'b1;
            end
        end
        if (stall_out && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mc_busy_q   <= 1'b0;
            mc_cnt_q    <= '0;
            mc_wr_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            mc_busy_q   <= mc_busy_d;
            mc_cnt_q    <= mc_cnt_d;
            mc_wr_q     <= mc_wr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        bus.forward_a = fwd_a;
        bus.forward_b = fwd_b;
        bus.stall_if  = stall_out;
        bus.stall_id  = stall_out;
        bus.bubble_ex = stall_out;
        bus.mc_busy   = mc_busy_q;
        bus.mc_done   = mc_busy_q && (mc_cnt_q == '0);
        bus.stall_cnt = stall_cnt_q;
    end
endmodule
